// File: rtl/dmem_dump_reader_if.sv
// Memory read port and transmit byte stream used by dmem_dump_reader.
// master = dump reader, slave = memory / debug UART side.
interface dmem_dump_reader_if;
  logic [31:0] o_mem_addr;
  logic        o_mem_read;
  logic [2:0]  o_mem_bhw_type;
  logic [31:0] i_mem_read_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;

  modport master (
    output o_mem_addr,
    output o_mem_read,
    output o_mem_bhw_type,
    input  i_mem_read_data,
    output o_tx_data,
    output o_tx_valid,
    input  i_tx_ready
  );

  modport slave (
    input  o_mem_addr,
    input  o_mem_read,
    input  o_mem_bhw_type,
    output i_mem_read_data,
    input  o_tx_data,
    input  o_tx_valid,
    output i_tx_ready
  );
endinterface

// File: rtl/dmem_dump_reader.sv
// Walks data memory word by word and streams it out little-endian.
// Define DMEM_DUMP_CHECKSUM_EN to append an XOR checksum byte.
module dmem_dump_reader #(
  parameter int unsigned MEM_BYTES  = 1016,
  parameter int unsigned START_ADDR = 0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  dmem_dump_reader_if.master bus,
  output logic o_busy,
  output logic o_done
);

  localparam logic [31:0] MEM_END = 32'(MEM_BYTES);
  localparam logic [31:0] BASE    = 32'(START_ADDR);

`ifdef DMEM_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, REQ, CAP, SEND, DONE, CSUM
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, REQ, CAP, SEND, DONE
  } state_t;
`endif

  state_t      state;
  logic [31:0] addr;
  logic [31:0] word_buf;
  logic [1:0]  idx;

  logic [31:0] addr_nxt;
  logic [1:0]  idx_nxt;
  logic [7:0]  byte_nxt;
  logic        last_word;
  logic        xfer;

`ifdef DMEM_DUMP_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign addr_nxt  = addr + 32'd4;
  assign idx_nxt   = idx + 2'd1;
  assign byte_nxt  = word_buf[{idx_nxt, 3'b000} +: 8];
  assign last_word = !(addr_nxt < MEM_END);
  assign xfer      = bus.o_tx_valid && bus.i_tx_ready;

  assign bus.o_mem_bhw_type = 3'b001;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      addr           <= '0;
      word_buf       <= '0;
      idx            <= '0;
      bus.o_mem_addr <= '0;
      bus.o_mem_read <= 1'b0;
      bus.o_tx_data  <= '0;
      bus.o_tx_valid <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
`ifdef DMEM_DUMP_CHECKSUM_EN
      csum           <= '0;
`endif
    end else begin
      bus.o_mem_read <= 1'b0;
      o_done         <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            addr           <= BASE;
            bus.o_mem_addr <= BASE;
            bus.o_mem_read <= 1'b1;
            o_busy         <= 1'b1;
            state          <= REQ;
`ifdef DMEM_DUMP_CHECKSUM_EN
            csum           <= '0;
`endif
          end
        end
        REQ: begin
          state <= CAP;
        end
        // memory data registered on the edge that ended REQ
        CAP: begin
          word_buf       <= bus.i_mem_read_data;
          idx            <= 2'd0;
          bus.o_tx_data  <= bus.i_mem_read_data[7:0];
          bus.o_tx_valid <= 1'b1;
          state          <= SEND;
        end
        SEND: begin
          if (xfer) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
            csum <= csum ^ bus.o_tx_data;
`endif
            if (idx != 2'd3) begin
              idx           <= idx_nxt;
              bus.o_tx_data <= byte_nxt;
            end else if (!last_word) begin
              addr           <= addr_nxt;
              bus.o_mem_addr <= addr_nxt;
              bus.o_mem_read <= 1'b1;
              bus.o_tx_valid <= 1'b0;
              state          <= REQ;
            end else begin
`ifdef DMEM_DUMP_CHECKSUM_EN
              bus.o_tx_data  <= csum ^ bus.o_tx_data;
              state          <= CSUM;
`else
              bus.o_tx_valid <= 1'b0;
              o_done         <= 1'b1;
              state          <= DONE;
`endif
            end
          end
        end
`ifdef DMEM_DUMP_CHECKSUM_EN
        CSUM: begin
          if (xfer) begin
            bus.o_tx_valid <= 1'b0;
            o_done         <= 1'b1;
            state          <= DONE;
          end
        end
`endif
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Scoreboard bench for dmem_dump_reader: queued expected bytes and
// read addresses, popped by a negedge monitor.
module tb_dmem_dump_reader;

  localparam int NWORDS = 254;
`ifdef DMEM_DUMP_CHECKSUM_EN
  localparam int NB = NWORDS * 4 + 1;
`else
  localparam int NB = NWORDS * 4;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [31:0] mem [0:255];

  int nvec;
  int nerr;
  int byte_cnt;
  int rd_cnt;
  int done_cnt;
  logic [31:0] max_addr;

  logic [7:0]  exp_q [$];
  logic [31:0] addr_q [$];

  dmem_dump_reader_if bus ();

  assign bus.i_mem_read_data = rdata;
  assign bus.i_tx_ready      = ready;

  dmem_dump_reader #(
    .MEM_BYTES (1016),
    .START_ADDR(0)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .i_start(start),
    .bus    (bus.master),
    .o_busy (busy),
    .o_done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.o_mem_read) rdata <= mem[bus.o_mem_addr[9:2]];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_tx_valid && ready) begin
        byte_cnt++;
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL extra_byte: got %h want none", bus.o_tx_data);
        end else begin
          chk("tx_byte", {24'd0, bus.o_tx_data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (bus.o_mem_read) begin
        rd_cnt++;
        if (bus.o_mem_addr > max_addr) max_addr = bus.o_mem_addr;
        chk("bhw_type", {29'd0, bus.o_mem_bhw_type}, 32'd1);
        if (addr_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL extra_read: got %h want none", bus.o_mem_addr);
        end else begin
          chk("read_addr", bus.o_mem_addr, addr_q.pop_front());
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic push_stream();
    logic [7:0] cs;
    cs = 8'h00;
    for (int w = 0; w < NWORDS; w++) begin
      addr_q.push_back(32'(w * 4));
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(mem[w][8*b +: 8]);
        cs = cs ^ mem[w][8*b +: 8];
      end
    end
`ifdef DMEM_DUMP_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input bit mid_start);
    int cyc;
    int d0;
    cyc = 0;
    d0  = done_cnt;
    while (done_cnt == d0 && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (mid_start && cyc == 300) start = 1'b1;
      if (mid_start && cyc == 301) start = 1'b0;
    end
    if (done_cnt == d0) begin
      nvec++;
      nerr++;
      $display("FAIL done_timeout: got no done want done within 3000");
    end else begin
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
    end
  endtask

  task automatic end_run(input int b0, input int d0);
    chk("byte_count", 32'(byte_cnt - b0), 32'(NB));
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    chk("max_addr", max_addr, 32'd1012);
    chk("exp_left", 32'(exp_q.size()), 32'd0);
    chk("addr_left", 32'(addr_q.size()), 32'd0);
  endtask

  initial begin
    int b0;
    int d0;
    int r0;
    int cyc;
    nvec = 0;
    nerr = 0;
    byte_cnt = 0;
    rd_cnt = 0;
    done_cnt = 0;
    max_addr = '0;
    start = 1'b0;
    ready = 1'b1;
    rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst = 1'b1;
    #3;
    chk("rst_addr", bus.o_mem_addr, 32'd0);
    chk("rst_read", {31'd0, bus.o_mem_read}, 32'd0);
    chk("rst_data", {24'd0, bus.o_tx_data}, 32'd0);
    chk("rst_valid", {31'd0, bus.o_tx_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // run 1: latency, byte order, backpressure
    mem[0]   = 32'h11223344;
    mem[1]   = 32'hDEADBEEF;
    mem[253] = 32'h0A0B0C0D;
    push_stream();
    b0 = byte_cnt;
    d0 = done_cnt;
    max_addr = '0;
    pulse_start();
    chk("read_e0", {31'd0, bus.o_mem_read}, 32'd1);
    chk("addr_e0", bus.o_mem_addr, 32'd0);
    chk("busy_e0", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1 chk("valid_e1", {31'd0, bus.o_tx_valid}, 32'd0);
    chk("read_e1", {31'd0, bus.o_mem_read}, 32'd0);
    @(posedge clk);
    #1 chk("valid_e2", {31'd0, bus.o_tx_valid}, 32'd1);
    chk("first_byte", {24'd0, bus.o_tx_data}, 32'h44);
    @(posedge clk);
    #1 ready = 1'b0;
    chk("hold_data", {24'd0, bus.o_tx_data}, 32'h33);
    repeat (5) begin
      @(posedge clk);
      #1 chk("hold_data", {24'd0, bus.o_tx_data}, 32'h33);
      chk("hold_valid", {31'd0, bus.o_tx_valid}, 32'd1);
      chk("hold_addr", bus.o_mem_addr, 32'd0);
    end
    ready = 1'b1;
    @(posedge clk);
    #1 chk("resume_data", {24'd0, bus.o_tx_data}, 32'h22);
    wait_done(1'b0);
    end_run(b0, d0);

    // run 2: mostly-zero memory, start pulse mid-dump ignored
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[253] = 32'h0A0B0C0D;
    push_stream();
    b0 = byte_cnt;
    d0 = done_cnt;
    max_addr = '0;
    pulse_start();
    wait_done(1'b1);
    end_run(b0, d0);

    // run 3: reset during SEND, then a clean restart
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = 32'h01020304;
    push_stream();
    pulse_start();
    cyc = 0;
    while (!bus.o_tx_valid && cyc < 20) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("reached_send", {31'd0, bus.o_tx_valid}, 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_valid", {31'd0, bus.o_tx_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_read", {31'd0, bus.o_mem_read}, 32'd0);
    chk("abort_addr", bus.o_mem_addr, 32'd0);
    exp_q.delete();
    addr_q.delete();
    b0 = byte_cnt;
    d0 = done_cnt;
    r0 = rd_cnt;
    #20;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_bytes", 32'(byte_cnt - b0), 32'd0);
    chk("idle_reads", 32'(rd_cnt - r0), 32'd0);
    chk("idle_done", 32'(done_cnt - d0), 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    push_stream();
    max_addr = '0;
    pulse_start();
    chk("restart_addr", bus.o_mem_addr, 32'd0);
    chk("restart_read", {31'd0, bus.o_mem_read}, 32'd1);
    wait_done(1'b0);
    end_run(b0, d0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
